c16_snd: RTL

//  Sound unit downstream of the c16 core. Consumes the core's one-cycle sound-register

---
 rtl/c16_snd.sv | 131 +++++++++++++
 1 files changed

// File: rtl/c16_snd.sv
// Sound unit: voice register bank written by the core, NUM_VOICES square-wave tone
// generators advanced on a shared sample tick, and a registered unsigned mix.
module c16_snd #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned TICK_DIV   = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        snd_wen,
    input  logic [1:0]  w_param,
    input  logic [10:0] w_index,
    input  logic [15:0] w_val,
    output logic [7:0]  sample,
    output logic        sample_valid,
    output logic [3:0]  voice_active
);

    localparam int unsigned DIV_W = $clog2(TICK_DIV);
    localparam int unsigned SUM_W = 6;

    logic [DIV_W-1:0] div_q;
    logic             tick_c;

    logic [15:0] period_q [NUM_VOICES];
    logic [15:0] period_n [NUM_VOICES];
    logic [15:0] cnt_q    [NUM_VOICES];
    logic [15:0] cnt_n    [NUM_VOICES];
    logic [15:0] dur_q    [NUM_VOICES];
    logic [15:0] dur_n    [NUM_VOICES];
    logic [3:0]  vol_q    [NUM_VOICES];
    logic [3:0]  vol_n    [NUM_VOICES];
    logic [1:0]  step_q   [NUM_VOICES];
    logic [1:0]  step_n   [NUM_VOICES];
    logic [NUM_VOICES-1:0] en_q, en_n;
    logic [NUM_VOICES-1:0] duty_q, duty_n;
    logic [SUM_W-1:0]      sum_c;

    assign tick_c = (div_q == DIV_W'(TICK_DIV - 1));

    // Next voice state: tick update first, then a same-cycle write overrides its fields.
    always_comb begin
        period_n = period_q;
        cnt_n    = cnt_q;
        dur_n    = dur_q;
        vol_n    = vol_q;
        step_n   = step_q;
        en_n     = en_q;
        duty_n   = duty_q;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (tick_c && en_q[v]) begin
                if (period_q[v] != 16'd0) begin
                    if (cnt_q[v] == period_q[v] - 16'd1) begin
                        cnt_n[v]  = 16'd0;
                        step_n[v] = step_q[v] + 2'd1;
                    end else begin
                        cnt_n[v] = cnt_q[v] + 16'd1;
                    end
                end
                if (dur_q[v] != 16'd0) begin
                    dur_n[v] = dur_q[v] - 16'd1;
                    if (dur_q[v] == 16'd1) begin
                        en_n[v] = 1'b0;
                    end
                end
            end
            if (snd_wen && (w_index == 11'(v))) begin
                case (w_param)
                    2'd0: begin
                        period_n[v] = w_val;
                        cnt_n[v]    = 16'd0;
                    end
                    2'd1: vol_n[v] = w_val[3:0];
                    2'd2: begin
                        en_n[v]   = w_val[0];
                        duty_n[v] = w_val[1];
                        if (w_val[0]) begin
                            cnt_n[v]  = 16'd0;
                            step_n[v] = 2'd0;
                        end
                    end
                    default: dur_n[v] = w_val;
                endcase
            end
        end
    end

    // Mix of current (pre-tick) voice amplitudes.
    always_comb begin
        sum_c = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (en_q[v] && (period_q[v] != 16'd0) &&
                (duty_q[v] ? (step_q[v] == 2'd0) : !step_q[v][1])) begin
                sum_c = sum_c + SUM_W'(vol_q[v]);
            end
        end
    end

    always_comb begin
        voice_active = '0;
        voice_active[NUM_VOICES-1:0] = en_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_q        <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            period_q     <= '{default: '0};
            cnt_q        <= '{default: '0};
            dur_q        <= '{default: '0};
            vol_q        <= '{default: '0};
            step_q       <= '{default: '0};
            en_q         <= '0;
            duty_q       <= '0;
        end else begin
            div_q        <= tick_c ? '0 : div_q + DIV_W'(1);
            sample_valid <= tick_c;
            if (tick_c) begin
                sample <= {sum_c, 2'b00};
            end
            period_q <= period_n;
            cnt_q    <= cnt_n;
            dur_q    <= dur_n;
            vol_q    <= vol_n;
            step_q   <= step_n;
            en_q     <= en_n;
            duty_q   <= duty_n;
        end
    end

endmodule
